// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and counter sizing for serial_subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit index counter width; never below one bit so WIDTH=2 still gets a register.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B, LSB first; SERIAL_SUB_SIGNED_OVF_EN adds Ovf
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  , output logic           Ovf
`endif
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr, b_sr;
  // Only WIDTH-1 partial bits are kept; the final bit goes straight into Diff.
  logic [WIDTH-2:0] res_sr;
  logic             bw;
  logic [CNT_W-1:0] cnt;
  logic             d, bout_c, last_bit, accept;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb, b_msb;
`endif

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bw),
    .d    (d),
    .bout (bout_c)
  );

  assign last_bit = (cnt == LAST_BIT);
  assign accept   = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bw     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      bw    <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
`endif
    end else if (state_q == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= (res_sr >> 1) | ((WIDTH-1)'(d) << (WIDTH - 2));
      bw     <= bout_c;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        Diff <= {d, res_sr};
        Bout <= bout_c;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        Ovf  <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
      end
    end
  end

endmodule
